game_flow_ctrl: RTL
===================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 3: consecutive tick samples at the same level needed to accept a new debounced button level.
REQ-002 Parameter OVER_HOLD_TICKS, default 100: ticks in GAME_OVER during which button presses are ignored (1 s at 100 Hz).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_100Hz  input  1  single-clk-cycle enable pulse at 100 Hz, synchronous to clk.
REQ-006 btn  input  1  flap button level, already synchronous to clk, active-high.
REQ-007 collision  input  1  level; bird overlaps a pipe or the ground.
REQ-008 pipe_passed  input  1  single-cycle pulse; bird cleared one pipe.
REQ-009 game_state  output  2  0 = GAME_INITIAL, 1 = GAME_PLAYING, 2 = GAME_OVER; value 3 is never driven.
REQ-010 flap  output  1  single-clk-cycle pulse commanding a bird jump.
REQ-011 scroll_en  output  1  high only in GAME_PLAYING; gates scene and pipe scrolling.
REQ-012 score  output  12  three BCD digits, [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-013 new_best  output  1  high while score exceeds the best score from previous rounds.

Function
REQ-014 Debounce: btn is sampled only in cycles where tick_100Hz=1; the debounced level changes after DEBOUNCE_TICKS consecutive equal samples that differ from it.
REQ-015 press event: one-clk-cycle internal pulse, asserted in the clk cycle after the tick that changes the debounced level from 0 to 1; a held button yields exactly one event.
REQ-016 GAME_INITIAL: on a press event, go to GAME_PLAYING, clear score to 000 and assert flap in the same cycle as the transition.
REQ-017 GAME_PLAYING: a press event asserts flap for that cycle and causes no state change.
REQ-018 GAME_PLAYING: pipe_passed=1 with collision=0 increments score by 1 in BCD, with carries 9->0 into the next digit.
REQ-019 score saturates at 999; a further pipe_passed leaves it at 999.
REQ-020 GAME_PLAYING with collision=1 goes to GAME_OVER next cycle and loads the hold counter with OVER_HOLD_TICKS.
REQ-021 collision and pipe_passed in the same cycle: collision wins and score is not incremented.
REQ-022 collision and a press event in the same cycle: collision wins and flap is not asserted.
REQ-023 GAME_OVER: the hold counter decrements by 1 per tick until it reaches 0, then stays at 0.
REQ-024 GAME_OVER: press events are ignored while the hold counter is nonzero.
REQ-025 GAME_OVER: with the hold counter at 0, a press event goes to GAME_INITIAL without asserting flap, and score holds its value until the next round starts.
REQ-026 Best score: on entering GAME_OVER, best is set to max(best, score) as a BCD magnitude compare.
REQ-027 new_best = (score > best) during GAME_PLAYING and GAME_OVER, and 0 in GAME_INITIAL.
REQ-028 collision and pipe_passed are ignored in GAME_INITIAL and GAME_OVER.
REQ-029 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-030 When rst_n=0, asynchronously: game_state=0, flap=0, scroll_en=0, score=000, new_best=0, best=000, hold counter=0, debounced level=0, debounce count=0.
REQ-031 Reset asserted mid-round aborts the round immediately; after release the block waits in GAME_INITIAL for a fresh press event.
REQ-032 If btn is held through reset release, no press event occurs until btn is released and pressed again.

Verification
REQ-033 Scenario 1: after reset, btn=1 for 3 ticks -> game_state 0->1 in one cycle, flap pulses exactly once, scroll_en=1, score=000.
REQ-034 Scenario 2: in PLAYING, 10 pipe_passed pulses -> score=0x010; 999 total pulses -> 0x999, one more pulse -> still 0x999.
REQ-035 Scenario 3: collision and pipe_passed in the same cycle at score 0x041 -> game_state=2 next cycle, score stays 0x041, scroll_en=0.
REQ-036 Scenario 4: in OVER, a press at tick 50 -> state stays 2; a press after tick 100 -> state 0, flap=0.
REQ-037 Scenario 5: round 1 ends at 0x012, round 2 reaches 0x013 -> new_best=1 from the 0x013 increment onward; best becomes 0x013 on entering OVER.
REQ-038 Scenario 6: rst_n pulsed low during PLAYING with btn held -> all outputs reset immediately and no flap occurs until btn is released and re-pressed.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// rtl/game_flow_ctrl_if.sv - stimulus/status bundle between the game scene and the flow controller
interface game_flow_ctrl_if;
    logic        tick_100Hz;
    logic        btn;
    logic        collision;
    logic        pipe_passed;
    logic [1:0]  game_state;
    logic        flap;
    logic        scroll_en;
    logic [11:0] score;
    logic        new_best;

    modport master (
        output tick_100Hz, btn, collision, pipe_passed,
        input  game_state, flap, scroll_en, score, new_best
    );

    modport slave (
        input  tick_100Hz, btn, collision, pipe_passed,
        output game_state, flap, scroll_en, score, new_best
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - round state machine with button debounce, BCD score and best-score tracking
module game_flow_ctrl #(
    parameter int DEBOUNCE_TICKS  = 3,
    parameter int OVER_HOLD_TICKS = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    game_flow_ctrl_if.slave gf
);

    localparam int DB_W   = (DEBOUNCE_TICKS  < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
    localparam int HOLD_W = (OVER_HOLD_TICKS < 2) ? 1 : $clog2(OVER_HOLD_TICKS + 1);

    typedef enum logic [1:0] {
        GAME_INITIAL = 2'd0,
        GAME_PLAYING = 2'd1,
        GAME_OVER    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                db_level_q, db_level_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic                press_q, press_d;
    logic                armed_q, armed_d;
    logic                flap_q, flap_d;
    logic                scroll_en_q, scroll_en_d;
    logic                new_best_q, new_best_d;
    logic [11:0]         score_q, score_d;
    logic [11:0]         best_q, best_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d2, d1, d0;
        {d2, d1, d0} = v;
        if (v == 12'h999) begin
            return v;
        end
        if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end
        end
        return {d2, d1, d0};
    endfunction

    // A button already held when reset releases must be seen low once before it can fire a press.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        press_d    = 1'b0;
        armed_d    = armed_q | ~gf.btn;
        if (gf.tick_100Hz) begin
            if (gf.btn != db_level_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
                    db_level_d = gf.btn;
                    db_cnt_d   = '0;
                    press_d    = gf.btn & armed_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            armed_q    <= armed_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GAME_INITIAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GAME_INITIAL: if (press_q)                          state_d = GAME_PLAYING;
            GAME_PLAYING: if (gf.collision)                     state_d = GAME_OVER;
            GAME_OVER:    if (press_q && (hold_q == '0))        state_d = GAME_INITIAL;
            default:                                            state_d = GAME_INITIAL;
        endcase
    end

    // Collision takes priority over both a flap and a pipe credit in the same cycle.
    always_comb begin
        flap_d  = 1'b0;
        score_d = score_q;
        best_d  = best_q;
        hold_d  = hold_q;
        case (state_q)
            GAME_INITIAL: begin
                if (press_q) begin
                    flap_d  = 1'b1;
                    score_d = 12'h000;
                end
            end
            GAME_PLAYING: begin
                if (gf.collision) begin
                    hold_d = HOLD_W'(OVER_HOLD_TICKS);
                    if (score_q > best_q) begin
                        best_d = score_q;
                    end
                end else begin
                    flap_d = press_q;
                    if (gf.pipe_passed) begin
                        score_d = bcd_inc(score_q);
                    end
                end
            end
            GAME_OVER: begin
                if (gf.tick_100Hz && (hold_q != '0)) begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                hold_d = '0;
            end
        endcase
        scroll_en_d = (state_d == GAME_PLAYING);
        new_best_d  = (state_d != GAME_INITIAL) && (score_d > best_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flap_q      <= 1'b0;
            scroll_en_q <= 1'b0;
            new_best_q  <= 1'b0;
            score_q     <= 12'h000;
            best_q      <= 12'h000;
            hold_q      <= '0;
        end else begin
            flap_q      <= flap_d;
            scroll_en_q <= scroll_en_d;
            new_best_q  <= new_best_d;
            score_q     <= score_d;
            best_q      <= best_d;
            hold_q      <= hold_d;
        end
    end

    assign gf.game_state = state_q;
    assign gf.flap       = flap_q;
    assign gf.scroll_en  = scroll_en_q;
    assign gf.new_best   = new_best_q;
    assign gf.score      = score_q;

endmodule
